// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: command encodings and controller states shared by the latch bank files.
package latch_bank_pkg;
  typedef enum logic [1:0] {
    CMD_WRITE = 2'b00,
    CMD_SET   = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_NOP   = 2'b11
  } cmd_t;
  typedef enum logic [1:0] {IDLE, STROBE, ACK} state_t;
endpackage

// File: rtl/latch_bank_ctrl_if.sv
// latch_bank_ctrl_if: two requester handshakes plus the flat latch outputs.
interface latch_bank_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW = 3
);
  logic req0, req1, ack0, ack1, err, busy;
  logic [1:0] cmd0, cmd1;
  logic [AW-1:0] addr0, addr1;
  logic [WIDTH-1:0] data0, data1;
  logic [DEPTH*WIDTH-1:0] q;
  modport master (
    output req0, cmd0, addr0, data0, req1, cmd1, addr1, data1,
    input ack0, ack1, err, busy, q
  );
  modport slave (
    input req0, cmd0, addr0, data0, req1, cmd1, addr1, data1,
    output ack0, ack1, err, busy, q
  );
endinterface

// File: rtl/mlatch.sv
// mlatch: set/reset/gated latch modelled as a transparent output over a clocked hold register.
module mlatch #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             s,
  input  logic             r,
  input  logic             g,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] val_reg;
  assign q = r ? '0 : s ? WIDTH'(1) : g ? d : val_reg;
  always_ff @(posedge clock or posedge r)
    if (r) val_reg <= '0;
    else val_reg <= q;
endmodule

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: round-robin arbiter and req/ack FSM driving one-cycle strobes into a bank of mlatch registers.
module latch_bank_ctrl
  import latch_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input logic clock,
  input logic reset,
  latch_bank_ctrl_if.slave bus
);
  state_t state;
  logic ptr, win, oor;
  logic both, pick, sel_oor;
  logic [1:0] sel_cmd;
  logic [AW-1:0] sel_addr;
  logic [WIDTH-1:0] sel_data, data_r;
  logic [DEPTH-1:0] hot, s_vec, r_vec, g_vec;
  always_comb begin
    both = bus.req0 & bus.req1;
    pick = both ? ptr : bus.req1;
    sel_cmd = pick ? bus.cmd1 : bus.cmd0;
    sel_addr = pick ? bus.addr1 : bus.addr0;
    sel_data = pick ? bus.data1 : bus.data0;
    sel_oor = 32'(sel_addr) >= DEPTH;
    hot = sel_oor ? '0 : DEPTH'(1) << sel_addr;
  end
  // Strobe vectors are decoded at grant so they are live for exactly the STROBE cycle.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= 1'b0;
      win <= 1'b0;
      oor <= 1'b0;
      data_r <= '0;
      s_vec <= '0;
      r_vec <= '0;
      g_vec <= '0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.err <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (bus.req0 | bus.req1) begin
            state <= STROBE;
            bus.busy <= 1'b1;
            win <= pick;
            oor <= sel_oor;
            data_r <= sel_data;
            g_vec <= sel_cmd == CMD_WRITE ? hot : '0;
            s_vec <= sel_cmd == CMD_SET ? hot : '0;
            r_vec <= sel_cmd == CMD_CLEAR ? hot : '0;
            if (both) ptr <= ~pick;
          end
        STROBE: begin
          state <= ACK;
          g_vec <= '0;
          s_vec <= '0;
          r_vec <= '0;
          bus.ack0 <= ~win;
          bus.ack1 <= win;
          bus.err <= oor;
        end
        ACK:
          if (!(win ? bus.req1 : bus.req0)) begin
            state <= IDLE;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.err <= 1'b0;
            bus.busy <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_bank
    mlatch #(.WIDTH(WIDTH)) u_latch (
      .clock(clock),
      .s(s_vec[i]),
      .r(r_vec[i] | reset),
      .g(g_vec[i]),
      .d(data_r),
      .q(bus.q[i*WIDTH +: WIDTH])
    );
  end
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: scoreboard bench with a behavioural latch-array model and random two-requester traffic.
module tb_latch_bank_ctrl;
  import latch_bank_pkg::*;
  localparam int W = 8;
  localparam int D = 6;
  localparam int A = 3;
  typedef struct {
    bit who;
    bit err;
    logic [D*W-1:0] q;
  } exp_t;
  logic clock = 1'b0;
  logic reset;
  int tests = 0;
  int fails = 0;
  logic [W-1:0] mem [D];
  bit mptr = 1'b0;
  exp_t sbq[$];
  logic [D*W-1:0] stq[$];
  logic pa0 = 1'b0, pa1 = 1'b0, pb = 1'b0;
  always #5 clock = ~clock;
  latch_bank_ctrl_if #(.WIDTH(W), .DEPTH(D), .AW(A)) bus ();
  latch_bank_ctrl #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic logic [D*W-1:0] flat();
    logic [D*W-1:0] f;
    for (int i = 0; i < D; i++) f[i*W +: W] = mem[i];
    return f;
  endfunction
  function automatic void push(bit who, logic [1:0] c, logic [A-1:0] a, logic [W-1:0] d);
    exp_t e;
    e.who = who;
    e.err = int'(a) >= D;
    if (!e.err) begin
      if (c == CMD_WRITE) mem[a] = d;
      else if (c == CMD_SET) mem[a] = W'(1);
      else if (c == CMD_CLEAR) mem[a] = '0;
    end
    e.q = flat();
    sbq.push_back(e);
    stq.push_back(e.q);
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < D; i++) mem[i] = '0;
    mptr = 1'b0;
  endfunction
  always @(negedge clock) begin
    if (reset) begin
      pa0 <= 1'b0;
      pa1 <= 1'b0;
      pb <= 1'b0;
    end else begin
      if (bus.busy && !pb) begin
        chk("strobe_pending", 64'(stq.size() > 0), 64'(1));
        if (stq.size() > 0) chk("strobe_q", 64'(bus.q), 64'(stq.pop_front()));
      end
      if ((bus.ack0 && !pa0) || (bus.ack1 && !pa1)) begin
        exp_t e;
        chk("one_ack", 64'(bus.ack0 & bus.ack1), 64'(0));
        chk("ack_pending", 64'(sbq.size() > 0), 64'(1));
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("ack_who", 64'(bus.ack1), 64'(e.who));
          chk("ack_err", 64'(bus.err), 64'(e.err));
          chk("q_after", 64'(bus.q), 64'(e.q));
        end
      end
      pa0 <= bus.ack0;
      pa1 <= bus.ack1;
      pb <= bus.busy;
    end
  end
  task automatic round(bit r0, bit r1, logic [1:0] c0, logic [A-1:0] a0, logic [W-1:0] d0,
                       logic [1:0] c1, logic [A-1:0] a1, logic [W-1:0] d1);
    bit first, s0, s1;
    int n, busy_n, first_ack;
    @(posedge clock); #1;
    bus.req0 = r0; bus.cmd0 = c0; bus.addr0 = a0; bus.data0 = d0;
    bus.req1 = r1; bus.cmd1 = c1; bus.addr1 = a1; bus.data1 = d1;
    first = (r0 && r1) ? mptr : r1;
    if (r0 && r1) mptr = ~first;
    if (first) push(1'b1, c1, a1, d1); else push(1'b0, c0, a0, d0);
    if (r0 && r1) begin
      if (first) push(1'b0, c0, a0, d0); else push(1'b1, c1, a1, d1);
    end
    busy_n = 0;
    first_ack = 0;
    for (n = 1; n <= 60; n++) begin
      @(negedge clock);
      s0 = bus.ack0;
      s1 = bus.ack1;
      if (bus.busy) busy_n++;
      if ((s0 || s1) && first_ack == 0) first_ack = n;
      if (!bus.req0 && !bus.req1 && !s0 && !s1 && !bus.busy) break;
      @(posedge clock); #1;
      if (s0) begin
        bus.req0 = 1'b0; bus.cmd0 = 2'($urandom); bus.addr0 = A'($urandom); bus.data0 = W'($urandom);
      end
      if (s1) begin
        bus.req1 = 1'b0; bus.cmd1 = 2'($urandom); bus.addr1 = A'($urandom); bus.data1 = W'($urandom);
      end
    end
    chk("round_timeout", 64'(n <= 60), 64'(1));
    chk("ack_latency", 64'(first_ack), 64'(3));
    chk("busy_cycles", 64'(busy_n), 64'(3 * (int'(r0) + int'(r1))));
  endtask
  initial begin
    int n, r;
    bus.req0 = 1'b0; bus.cmd0 = CMD_NOP; bus.addr0 = '0; bus.data0 = '0;
    bus.req1 = 1'b0; bus.cmd1 = CMD_NOP; bus.addr1 = '0; bus.data1 = '0;
    reset = 1'b1;
    model_reset();
    #12;
    chk("rst_ack0", 64'(bus.ack0), 64'(0));
    chk("rst_ack1", 64'(bus.ack1), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_q", 64'(bus.q), 64'(0));
    @(negedge clock); reset = 1'b0;
    round(1, 0, CMD_WRITE, 3'd2, 8'hA5, CMD_NOP, 3'd0, 8'h00);
    chk("write_a5", 64'(bus.q[23:16]), 64'(8'hA5));
    round(0, 1, CMD_NOP, 3'd0, 8'h00, CMD_SET, 3'd5, 8'hEE);
    chk("set_5", 64'(bus.q[47:40]), 64'(8'h01));
    round(0, 1, CMD_NOP, 3'd0, 8'h00, CMD_CLEAR, 3'd5, 8'hEE);
    chk("clear_5", 64'(bus.q[47:40]), 64'(8'h00));
    round(1, 1, CMD_WRITE, 3'd0, 8'h11, CMD_WRITE, 3'd1, 8'h22);
    round(1, 1, CMD_WRITE, 3'd0, 8'h11, CMD_WRITE, 3'd1, 8'h22);
    chk("pair_l0", 64'(bus.q[7:0]), 64'(8'h11));
    chk("pair_l1", 64'(bus.q[15:8]), 64'(8'h22));
    round(1, 0, CMD_WRITE, 3'd7, 8'hFF, CMD_NOP, 3'd0, 8'h00);
    round(0, 1, CMD_SET, 3'd0, 8'h00, CMD_SET, 3'd6, 8'h00);
    @(posedge clock); #1;
    bus.req0 = 1'b1; bus.cmd0 = CMD_WRITE; bus.addr0 = 3'd4; bus.data0 = 8'h3C;
    push(1'b0, CMD_WRITE, 3'd4, 8'h3C);
    for (n = 0; n < 10 && !bus.ack0; n++) @(negedge clock);
    chk("mid_ack_seen", 64'(bus.ack0), 64'(1));
    chk("mid_q", 64'(bus.q[39:32]), 64'(8'h3C));
    #2 reset = 1'b1;
    #1;
    chk("abort_ack0", 64'(bus.ack0), 64'(0));
    chk("abort_q", 64'(bus.q), 64'(0));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    bus.req0 = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("post_rst_busy", 64'(bus.busy), 64'(0));
    chk("post_rst_q", 64'(bus.q), 64'(0));
    round(1, 0, CMD_WRITE, 3'd3, 8'h5A, CMD_NOP, 3'd0, 8'h00);
    repeat (20) begin
      @(posedge clock); #1;
      bus.addr0 = A'($urandom); bus.data0 = W'($urandom); bus.cmd0 = 2'($urandom);
      @(negedge clock);
      chk("hold_q", 64'(bus.q), 64'(flat()));
      chk("hold_busy", 64'(bus.busy), 64'(0));
    end
    chk("hold_5a", 64'(bus.q[31:24]), 64'(8'h5A));
    repeat (60) begin
      r = int'($urandom_range(1, 3));
      round(r[0], r[1], 2'($urandom), A'($urandom), W'($urandom),
            2'($urandom), A'($urandom), W'($urandom));
    end
    @(negedge clock);
    chk("sb_drained", 64'(sbq.size() + stq.size()), 64'(0));
    chk("final_q", 64'(bus.q), 64'(flat()));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
